// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for single-port data memory (DMEM_ARB_FIXED_PRIO_EN: A always wins ties).
// Latency: gnt one cycle after req, ack WAIT_CYCLES+1 cycles after req; one transaction per WAIT_CYCLES+2 cycles.
// Backpressure: requesters hold req until ack; a request arriving while busy waits in place and is never dropped.
module dmem_arbiter #(
  parameter int BITSIZE     = 32,
  parameter int MEMSIZE     = 64,
  parameter int WAIT_CYCLES = 1,
  localparam int AW         = $clog2(MEMSIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [AW-1:0]      a_addr,
  input  logic [BITSIZE-1:0] a_wdata,
  output logic               a_gnt,
  output logic               a_ack,
  output logic [BITSIZE-1:0] a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [AW-1:0]      b_addr,
  input  logic [BITSIZE-1:0] b_wdata,
  output logic               b_gnt,
  output logic               b_ack,
  output logic [BITSIZE-1:0] b_rdata,
  output logic [AW-1:0]      mem_addr,
  output logic [BITSIZE-1:0] mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [BITSIZE-1:0] mem_rdata,
  output logic               busy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                owner_q, owner_d;   // 1 = port B
  logic                we_q, we_d;
  logic                sel_b, grant;
  logic [AW-1:0]       addr_d;
  logic [BITSIZE-1:0]  wdata_d, a_rdata_d, b_rdata_d;
  logic                rd_d, wr_d, a_gnt_d, b_gnt_d, a_ack_d, b_ack_d, busy_d;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign sel_b = b_req & ~a_req;
`else
  logic last_b_q;

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_b_q <= 1'b1;
    else if (grant) last_b_q <= sel_b;
  end

  assign sel_b = b_req & (~a_req | ~last_b_q);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    a_rdata_d = a_rdata;
    b_rdata_d = b_rdata;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    a_gnt_d   = 1'b0;
    b_gnt_d   = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    grant     = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant   = 1'b1;
          owner_d = sel_b;
          we_d    = sel_b ? b_we    : a_we;
          addr_d  = sel_b ? b_addr  : a_addr;
          wdata_d = sel_b ? b_wdata : a_wdata;
          cnt_d   = '0;
          rd_d    = ~we_d;
          wr_d    = we_d;
          a_gnt_d = ~sel_b;
          b_gnt_d = sel_b;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST) begin
          a_ack_d = ~owner_q;
          b_ack_d = owner_q;
          if (!we_q) begin
            if (owner_q) b_rdata_d = mem_rdata;
            else         a_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          // Write strobe is only ever in the first cycle; reads stay asserted.
          cnt_d = cnt_q + 1'b1;
          rd_d  = ~we_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_read  <= rd_d;
      mem_write <= wr_d;
      a_gnt     <= a_gnt_d;
      b_gnt     <= b_gnt_d;
      a_ack     <= a_ack_d;
      b_ack     <= b_ack_d;
      a_rdata   <= a_rdata_d;
      b_rdata   <= b_rdata_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: main instance with WAIT_CYCLES=1 and a second with WAIT_CYCLES=3.
module tb_dmem_arbiter;
  localparam int BW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic preload;

  logic          a_req, a_we, a_gnt, a_ack;
  logic [AW-1:0] a_addr;
  logic [BW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_ack;
  logic [AW-1:0] b_addr;
  logic [BW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write, busy;

  logic          x_a_req, x_a_we, x_a_gnt, x_a_ack;
  logic [AW-1:0] x_a_addr;
  logic [BW-1:0] x_a_wdata, x_a_rdata;
  logic          x_b_req, x_b_we, x_b_gnt, x_b_ack;
  logic [AW-1:0] x_b_addr;
  logic [BW-1:0] x_b_wdata, x_b_rdata;
  logic [AW-1:0] x_mem_addr;
  logic [BW-1:0] x_mem_wdata, x_mem_rdata;
  logic          x_mem_read, x_mem_write, x_busy;

  logic [BW-1:0] mem [0:63];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int wr0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BITSIZE(BW), .MEMSIZE(64), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.BITSIZE(BW), .MEMSIZE(64), .WAIT_CYCLES(3)) dut_slow (
    .clk(clk), .rst(rst),
    .a_req(x_a_req), .a_we(x_a_we), .a_addr(x_a_addr), .a_wdata(x_a_wdata),
    .a_gnt(x_a_gnt), .a_ack(x_a_ack), .a_rdata(x_a_rdata),
    .b_req(x_b_req), .b_we(x_b_we), .b_addr(x_b_addr), .b_wdata(x_b_wdata),
    .b_gnt(x_b_gnt), .b_ack(x_b_ack), .b_rdata(x_b_rdata),
    .mem_addr(x_mem_addr), .mem_wdata(x_mem_wdata), .mem_read(x_mem_read),
    .mem_write(x_mem_write), .mem_rdata(x_mem_rdata), .busy(x_busy)
  );

  // Asynchronous-read memory for the main instance; the slow instance sees an address-derived pattern.
  assign mem_rdata   = mem[mem_addr];
  assign x_mem_rdata = {26'h0, x_mem_addr} ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[3] <= 32'd3;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    preload = 1; rst = 0;
    idle_inputs();
    x_a_req = 0; x_a_we = 0; x_a_addr = '0; x_a_wdata = '0;
    x_b_req = 0; x_b_we = 0; x_b_addr = '0; x_b_wdata = '0;
    tick();
    preload = 0;
    check_val("rst_gnt",   {30'h0, a_gnt, b_gnt}, 0);
    check_val("rst_ack",   {30'h0, a_ack, b_ack}, 0);
    check_val("rst_mem",   {29'h0, mem_read, mem_write, busy}, 0);
    check_val("rst_addr",  32'(mem_addr), 0);
    check_val("rst_rdata", a_rdata | b_rdata, 0);
    rst = 1;

    // B-only read of preloaded word
    b_req = 1; b_we = 0; b_addr = 6'd3;
    tick();
    check_val("b_rd_gnt",   {30'h0, a_gnt, b_gnt}, 32'b01);
    check_val("b_rd_mrd",   32'(mem_read), 1);
    check_val("b_rd_maddr", 32'(mem_addr), 3);
    check_val("b_rd_busy",  32'(busy), 1);
    tick();
    check_val("b_rd_ack",   {30'h0, a_ack, b_ack}, 32'b01);
    check_val("b_rd_data",  b_rdata, 3);
    check_val("b_rd_adata", a_rdata, 0);
    check_val("b_rd_mrd2",  32'(mem_read), 0);
    b_req = 0;
    tick();
    check_val("b_rd_idle",  32'(busy), 0);
    check_val("b_rd_hold",  b_rdata, 3);

    // A write then read back; operands scrambled after gnt
    do_reset();
    wr0 = wr_cnt;
    a_req = 1; a_we = 1; a_addr = 6'd5; a_wdata = 32'hDEADBEEF;
    tick();
    check_val("wr_gnt",   {30'h0, a_gnt, b_gnt}, 32'b10);
    check_val("wr_mwr",   32'(mem_write), 1);
    check_val("wr_mrd",   32'(mem_read), 0);
    check_val("wr_maddr", 32'(mem_addr), 5);
    a_addr = 6'd0; a_wdata = 32'h0;
    tick();
    check_val("wr_ack",   {30'h0, a_ack, b_ack}, 32'b10);
    check_val("wr_mwr2",  32'(mem_write), 0);
    a_req = 0;
    tick();
    check_val("wr_mem5",  mem[5], 32'hDEADBEEF);
    check_val("wr_count", 32'(wr_cnt - wr0), 1);
    a_req = 1; a_we = 0; a_addr = 6'd5;
    tick();
    check_val("rd_gnt",   32'(a_gnt), 1);
    check_val("rd_mrd",   32'(mem_read), 1);
    check_val("rd_mwr",   32'(mem_write), 0);
    tick();
    check_val("rd_ack",   32'(a_ack), 1);
    check_val("rd_data",  a_rdata, 32'hDEADBEEF);
    a_req = 0;
    tick();
    check_val("rd_count", 32'(wr_cnt - wr0), 1);

    // Both ports requesting continuously
    do_reset();
    a_req = 1; b_req = 1; a_addr = 6'd1; b_addr = 6'd2;
    for (int c = 1; c <= 12; c++) begin
      logic ph_g, ph_a, own_b;
      tick();
      ph_g = ((c - 1) % 3) == 0;
      ph_a = ((c - 1) % 3) == 1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      own_b = 1'b0;
`else
      own_b = (((c - 1) / 3) % 2) == 1;
`endif
      check_val($sformatf("tie_gnt_c%0d", c), {30'h0, a_gnt, b_gnt}, {30'h0, ph_g & ~own_b, ph_g & own_b});
      check_val($sformatf("tie_ack_c%0d", c), {30'h0, a_ack, b_ack}, {30'h0, ph_a & ~own_b, ph_a & own_b});
    end
    a_req = 0;
    tick();
    check_val("tie_b_after_a", {30'h0, a_gnt, b_gnt}, 32'b01);
    tick();
    check_val("tie_b_ack", {30'h0, a_ack, b_ack}, 32'b01);
    b_req = 0;
    tick();

    // Reset in the middle of a B write
    do_reset();
    wr0 = wr_cnt;
    b_req = 1; b_we = 1; b_addr = 6'd7; b_wdata = 32'h12345678;
    tick();
    check_val("mid_gnt", 32'(b_gnt), 1);
    check_val("mid_mwr", 32'(mem_write), 1);
    #2;
    rst = 0;
    #1;
    check_val("mid_rst_ctl",   {27'h0, b_gnt, b_ack, mem_write, mem_read, busy}, 0);
    check_val("mid_rst_addr",  32'(mem_addr), 0);
    check_val("mid_rst_wdata", mem_wdata, 0);
    a_req = 1; a_we = 0; a_addr = 6'd1;
    @(posedge clk);
    #1;
    rst = 1;
    tick();
    check_val("mid_a_first", {30'h0, a_gnt, b_gnt}, 32'b10);
    check_val("mid_no_back", 32'(b_ack), 0);
    tick();
    check_val("mid_a_ack", {30'h0, a_ack, b_ack}, 32'b10);
    a_req = 0; b_req = 0;
    tick();
    check_val("mid_mem7",  mem[7], 0);
    check_val("mid_count", 32'(wr_cnt - wr0), 0);
    tick();

    // Extended latency on the WAIT_CYCLES=3 instance; req dropped right after gnt
    x_a_req = 1; x_a_we = 0; x_a_addr = 6'd9;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check_val($sformatf("slow_mrd_c%0d", c),  32'(x_mem_read), 32'(c <= 3));
      check_val($sformatf("slow_ack_c%0d", c),  32'(x_a_ack),    32'(c == 4));
      check_val($sformatf("slow_busy_c%0d", c), 32'(x_busy),     32'(c <= 4));
      check_val($sformatf("slow_gnt_c%0d", c),  32'(x_a_gnt),    32'(c == 1));
      if (c == 1) x_a_req = 0;
      if (c == 2) check_val("slow_maddr", 32'(x_mem_addr), 9);
      if (c == 4) check_val("slow_rdata", x_a_rdata, 32'hA5A5_0009);
    end
    check_val("slow_b_quiet", {30'h0, x_b_gnt, x_b_ack} | x_b_rdata, 0);
    check_val("slow_no_wr",   {31'h0, x_mem_write} | x_mem_wdata, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
